// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Multi-mode LED pattern generator. A prescaler produces a
//                periodic step tick; four patterns (binary count, blink,
//                bouncing scanner, breathe) are gated by a global PWM duty
//                and driven out through a registered, polarity-selectable
//                LED port.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int CLK_HZ     = 12000000,
    parameter int TICK_HZ    = 16,
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode_in,
    input  logic                mode_load,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [1:0]          mode,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = $clog2(DIV);
    localparam int SCAN_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [NUM_LEDS-1:0] LED_OFF   = {NUM_LEDS{ACTIVE_LOW}};

    // Pattern selector encoding
    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_SCAN    = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRESC_W-1:0]  presc_q;
    logic                tick_q;

    logic [1:0]          mode_q,       mode_d;
    logic [1:0]          pending_q,    pending_d;
    logic                pend_vld_q,   pend_vld_d;

    logic [NUM_LEDS-1:0] count_q,      count_d;
    logic                blink_ph_q,   blink_ph_d;
    logic [SCAN_W-1:0]   scan_pos_q,   scan_pos_d;
    logic                scan_down_q,  scan_down_d;
    logic [PWM_BITS-1:0] lvl_q,        lvl_d;
    logic                lvl_down_q,   lvl_down_d;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [NUM_LEDS-1:0] led_q,        led_d;

    // Combinational output-stage signals
    logic [NUM_LEDS-1:0] pattern;
    logic [PWM_BITS-1:0] duty;
    logic                lit;

    // ------------------------------------------------------------------------
    // Prescaler: wraps every DIV cycles, tick is registered one cycle later
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (presc_q == PRESC_MAX);
            if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register: active mode, pending request and all pattern state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_COUNT;
            pending_q   <= MODE_COUNT;
            pend_vld_q  <= 1'b0;
            count_q     <= '0;
            blink_ph_q  <= 1'b0;
            scan_pos_q  <= '0;
            scan_down_q <= 1'b0;
            lvl_q       <= '0;
            lvl_down_q  <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            pend_vld_q  <= pend_vld_d;
            count_q     <= count_d;
            blink_ph_q  <= blink_ph_d;
            scan_pos_q  <= scan_pos_d;
            scan_down_q <= scan_down_d;
            lvl_q       <= lvl_d;
            lvl_down_q  <= lvl_down_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: capture mode requests, apply them on a tick, else step
    // ------------------------------------------------------------------------
    always_comb begin
        mode_d      = mode_q;
        pending_d   = pending_q;
        pend_vld_d  = pend_vld_q;
        count_d     = count_q;
        blink_ph_d  = blink_ph_q;
        scan_pos_d  = scan_pos_q;
        scan_down_d = scan_down_q;
        lvl_d       = lvl_q;
        lvl_down_d  = lvl_down_q;

        // A load coinciding with a tick is kept as pending for the next tick,
        // while the request already pending is consumed by this tick.
        if (mode_load) begin
            pending_d  = mode_in;
            pend_vld_d = 1'b1;
        end else if (tick_q && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end

        if (tick_q) begin
            if (pend_vld_q) begin
                // Mode switch restarts every pattern; no step this tick.
                mode_d      = pending_q;
                count_d     = '0;
                blink_ph_d  = 1'b0;
                scan_pos_d  = '0;
                scan_down_d = 1'b0;
                lvl_d       = '0;
                lvl_down_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_COUNT: begin
                        count_d = count_q + NUM_LEDS'(1);
                    end
                    MODE_BLINK: begin
                        blink_ph_d = ~blink_ph_q;
                    end
                    MODE_SCAN: begin
                        // Reflect at the ends so each endpoint is lit once per sweep.
                        if (NUM_LEDS > 1) begin
                            if (!scan_down_q) begin
                                if (scan_pos_q == SCAN_LAST) begin
                                    scan_down_d = 1'b1;
                                    scan_pos_d  = SCAN_LAST - SCAN_W'(1);
                                end else begin
                                    scan_pos_d  = scan_pos_q + SCAN_W'(1);
                                end
                            end else begin
                                if (scan_pos_q == '0) begin
                                    scan_down_d = 1'b0;
                                    scan_pos_d  = SCAN_W'(1);
                                end else begin
                                    scan_pos_d  = scan_pos_q - SCAN_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        // Breathe: triangle wave over the full duty range.
                        if (!lvl_down_q) begin
                            if (lvl_q == LVL_MAX) begin
                                lvl_down_d = 1'b1;
                                lvl_d      = LVL_MAX - PWM_BITS'(1);
                            end else begin
                                lvl_d      = lvl_q + PWM_BITS'(1);
                            end
                        end else begin
                            if (lvl_q == '0) begin
                                lvl_down_d = 1'b0;
                                lvl_d      = PWM_BITS'(1);
                            end else begin
                                lvl_d      = lvl_q - PWM_BITS'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode: pattern bits, PWM gate and polarity
    // ------------------------------------------------------------------------
    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_COUNT:   pattern = count_q;
            MODE_BLINK:   pattern = blink_ph_q ? {NUM_LEDS{1'b1}} : '0;
            MODE_SCAN:    pattern = NUM_LEDS'(1) << scan_pos_q;
            default:      pattern = {NUM_LEDS{1'b1}};
        endcase

        duty = (mode_q == MODE_BREATHE) ? lvl_q : brightness;

        // Full-scale duty must be 100 %, which the plain compare cannot reach.
        lit = (duty == LVL_MAX) || (pwm_cnt_q < duty);

        led_d = pattern & {NUM_LEDS{lit}};
        if (ACTIVE_LOW) begin
            led_d = ~led_d;
        end
    end

    // ------------------------------------------------------------------------
    // PWM counter and registered LED drive
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            led_q     <= LED_OFF;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            led_q     <= led_d;
        end
    end

    assign mode = mode_q;
    assign tick = tick_q;
    assign led  = led_q;

endmodule
`default_nettype wire
